// File: rtl/pwm_ramp_ctrl.sv
// APB write sequencer for one PWM slave: programs period/pulse width at start-up,
// then slews PULSE_WIDTH toward commanded targets in bounded, evenly spaced steps.
`timescale 1ns/1ps
module pwm_ramp_ctrl #(
    parameter logic [15:0] PWM_BASE_ADDR    = 16'h0000,
    parameter logic [31:0] INIT_PERIOD_CC   = 32'd5000,
    parameter logic [31:0] INIT_PULSE_CC    = 32'd0,
    parameter logic [31:0] STEP             = 32'd50,
    parameter logic [31:0] STEP_INTERVAL_CC = 32'd1000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        CMD_VALID,
    input  logic [31:0] CMD_TARGET,
    output logic        CMD_READY,
    output logic        M_PSEL,
    output logic        M_PENABLE,
    output logic        M_PWRITE,
    output logic [31:0] M_PADDR,
    output logic [31:0] M_PWDATA,
    input  logic        M_PREADY,
    input  logic        M_PSLVERR,
    output logic [31:0] CUR_PW,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_INIT_PER = 3'd0,
        S_INIT_PW  = 3'd1,
        S_IDLE     = 3'd2,
        S_WAIT     = 3'd3,
        S_SETUP    = 3'd4,
        S_ACCESS   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        X_PER  = 2'd0,
        X_PW   = 2'd1,
        X_STEP = 2'd2
    } xfer_t;

    localparam logic [31:0] ADDR_PER = {16'h0000, PWM_BASE_ADDR};
    localparam logic [31:0] ADDR_PW  = {16'h0000, PWM_BASE_ADDR + 16'd4};
    localparam logic [31:0] CNT_LAST = STEP_INTERVAL_CC - 32'd1;

    state_t      r_state, w_state_nxt;
    xfer_t       r_kind, w_kind_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic [31:0] r_cur, w_cur_nxt;
    logic        r_psel, w_psel_nxt;
    logic        r_penable, w_penable_nxt;
    logic        r_pwrite, w_pwrite_nxt;
    logic [31:0] r_paddr, w_paddr_nxt;
    logic [31:0] r_pwdata, w_pwdata_nxt;
    logic        r_err, w_err_nxt;
    logic        r_cmd_ready;
    logic        r_busy;

    logic        w_accept;
    logic [31:0] w_cmd_clamp;
    logic [31:0] w_tgt_eff;
    logic        w_up;
    logic [31:0] w_diff;
    logic [31:0] w_step_val;

    // A command accepted in WAIT is used immediately, including for a step computed that same cycle.
    assign w_accept    = CMD_VALID & r_cmd_ready;
    assign w_cmd_clamp = (CMD_TARGET > INIT_PERIOD_CC) ? INIT_PERIOD_CC : CMD_TARGET;
    assign w_tgt_eff   = w_accept ? w_cmd_clamp : r_target;
    assign w_up        = (w_tgt_eff > r_cur);
    assign w_diff      = w_up ? (w_tgt_eff - r_cur) : (r_cur - w_tgt_eff);
    assign w_step_val  = (w_diff <= STEP) ? w_tgt_eff
                       : (w_up ? (r_cur + STEP) : (r_cur - STEP));

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_kind_nxt    = r_kind;
        w_cnt_nxt     = r_cnt;
        w_target_nxt  = r_target;
        w_cur_nxt     = r_cur;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_pwrite_nxt  = r_pwrite;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_err_nxt     = r_err;
        case (r_state)
            S_INIT_PER: begin
                w_psel_nxt    = 1'b1;
                w_pwrite_nxt  = 1'b1;
                w_penable_nxt = 1'b0;
                w_paddr_nxt   = ADDR_PER;
                w_pwdata_nxt  = INIT_PERIOD_CC;
                w_kind_nxt    = X_PER;
                w_state_nxt   = S_SETUP;
            end
            S_INIT_PW: begin
                w_psel_nxt    = 1'b1;
                w_pwrite_nxt  = 1'b1;
                w_penable_nxt = 1'b0;
                w_paddr_nxt   = ADDR_PW;
                w_pwdata_nxt  = INIT_PULSE_CC;
                w_kind_nxt    = X_PW;
                w_state_nxt   = S_SETUP;
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_target_nxt = w_cmd_clamp;
                    if (w_cmd_clamp != r_cur) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 32'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_accept) begin
                    w_target_nxt = w_cmd_clamp;
                end else begin
                    w_target_nxt = r_target;
                end
                // Retargeting keeps the interval phase so a ramp cannot be stalled by repeated commands.
                if (w_tgt_eff == r_cur) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_psel_nxt    = 1'b1;
                    w_pwrite_nxt  = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_paddr_nxt   = ADDR_PW;
                    w_pwdata_nxt  = w_step_val;
                    w_kind_nxt    = X_STEP;
                    w_state_nxt   = S_SETUP;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = S_ACCESS;
            end
            S_ACCESS: begin
                if (M_PREADY) begin
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_pwrite_nxt  = 1'b0;
                    if (M_PSLVERR) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_err_nxt = r_err;
                    end
                    case (r_kind)
                        X_PER:   w_state_nxt = S_INIT_PW;
                        X_PW:    w_state_nxt = S_IDLE;
                        X_STEP: begin
                            if (M_PSLVERR) begin
                                w_target_nxt = r_cur;
                                w_state_nxt  = S_IDLE;
                            end else begin
                                w_cur_nxt = r_pwdata;
                                if (r_pwdata == r_target) begin
                                    w_state_nxt = S_IDLE;
                                end else begin
                                    w_state_nxt = S_WAIT;
                                    w_cnt_nxt   = 32'd0;
                                end
                            end
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end else begin
                    w_state_nxt = S_ACCESS;
                end
            end
            default: begin
                w_state_nxt = S_INIT_PER;
            end
        endcase
    end

    // State and registered-output update; CMD_READY/BUSY are decoded from the next state.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= S_INIT_PER;
            r_kind      <= X_PER;
            r_cnt       <= 32'd0;
            r_target    <= INIT_PULSE_CC;
            r_cur       <= INIT_PULSE_CC;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= 32'd0;
            r_pwdata    <= 32'd0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_kind      <= w_kind_nxt;
            r_cnt       <= w_cnt_nxt;
            r_target    <= w_target_nxt;
            r_cur       <= w_cur_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_err       <= w_err_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign CMD_READY = r_cmd_ready;
    assign M_PSEL    = r_psel;
    assign M_PENABLE = r_penable;
    assign M_PWRITE  = r_pwrite;
    assign M_PADDR   = r_paddr;
    assign M_PWDATA  = r_pwdata;
    assign CUR_PW    = r_cur;
    assign BUSY      = r_busy;
    assign ERR       = r_err;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios plus random ramps against an arithmetic ramp model.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic [31:0] CMD_TARGET = 32'd0;
    logic        CMD_READY;
    logic        M_PSEL, M_PENABLE, M_PWRITE;
    logic [31:0] M_PADDR, M_PWDATA;
    logic        M_PREADY, M_PSLVERR;
    logic [31:0] CUR_PW;
    logic        BUSY, ERR;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int proto_err = 0;
    int ws_req = 0;
    int ws_left = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_data = 32'd0;
    logic        prev_psel = 1'b0;
    logic [31:0] s_addr = 32'd0;
    logic [31:0] s_data = 32'd0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
    } wr_t;
    wr_t wq[$];
    int  st[$];

    pwm_ramp_ctrl #(
        .PWM_BASE_ADDR   (16'h0000),
        .INIT_PERIOD_CC  (32'd5000),
        .INIT_PULSE_CC   (32'd0),
        .STEP            (32'd50),
        .STEP_INTERVAL_CC(32'd4)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .CMD_VALID (CMD_VALID),
        .CMD_TARGET(CMD_TARGET),
        .CMD_READY (CMD_READY),
        .M_PSEL    (M_PSEL),
        .M_PENABLE (M_PENABLE),
        .M_PWRITE  (M_PWRITE),
        .M_PADDR   (M_PADDR),
        .M_PWDATA  (M_PWDATA),
        .M_PREADY  (M_PREADY),
        .M_PSLVERR (M_PSLVERR),
        .CUR_PW    (CUR_PW),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    always #5 PCLK = ~PCLK;

    assign M_PREADY  = !(M_PSEL && M_PENABLE && (ws_left != 0));
    assign M_PSLVERR = err_en && M_PSEL && M_PENABLE && M_PREADY && (M_PWDATA == err_data);

    // Bus monitor and slave wait-state generator.
    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (PRESET) begin
            prev_psel <= 1'b0;
            ws_left   <= 0;
        end else begin
            if ((M_PWRITE !== M_PSEL) || (M_PENABLE && !M_PSEL)) proto_err <= proto_err + 1;
            if (M_PSEL && !M_PENABLE) begin
                if (prev_psel) proto_err <= proto_err + 1;
                s_addr  <= M_PADDR;
                s_data  <= M_PWDATA;
                ws_left <= ws_req;
                st.push_back(cyc);
            end
            if (M_PSEL && M_PENABLE) begin
                if ((M_PADDR !== s_addr) || (M_PWDATA !== s_data)) proto_err <= proto_err + 1;
                if (ws_left != 0) ws_left <= ws_left - 1;
                if (M_PREADY) wq.push_back('{a: M_PADDR, d: M_PWDATA, e: M_PSLVERR});
            end
            prev_psel <= M_PSEL;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] clamp(input logic [31:0] t);
        return (t > 32'd5000) ? 32'd5000 : t;
    endfunction

    // One ramp step: move at most 50 toward the target.
    function automatic logic [31:0] step_model(input logic [31:0] cur, input logic [31:0] tgt);
        if (cur < tgt) return (tgt - cur <= 32'd50) ? tgt : cur + 32'd50;
        else           return (cur - tgt <= 32'd50) ? tgt : cur - 32'd50;
    endfunction

    task automatic check_ramp(input string tag, input logic [31:0] from, input logic [31:0] tgt_raw,
                              input int base, output int nwr);
        logic [31:0] tgt;
        logic [31:0] cur;
        int n;
        tgt = clamp(tgt_raw);
        cur = from;
        n = 0;
        while (cur != tgt) begin
            cur = step_model(cur, tgt);
            if (base + n < wq.size()) begin
                chk({tag, "_addr"}, wq[base+n].a, 32'd4);
                chk({tag, "_data"}, wq[base+n].d, cur);
                chk({tag, "_slverr"}, {31'd0, wq[base+n].e}, 32'd0);
            end else begin
                chk({tag, "_missing_write"}, wq.size(), base + n + 1);
            end
            n++;
        end
        nwr = n;
    endtask

    task automatic reset_checks(input string tag);
        PRESET = 1'b1;
        CMD_VALID = 1'b0;
        @(posedge PCLK);
        #1;
        chk({tag, "_psel"}, {31'd0, M_PSEL}, 32'd0);
        chk({tag, "_penable"}, {31'd0, M_PENABLE}, 32'd0);
        chk({tag, "_pwrite"}, {31'd0, M_PWRITE}, 32'd0);
        chk({tag, "_paddr"}, M_PADDR, 32'd0);
        chk({tag, "_pwdata"}, M_PWDATA, 32'd0);
        chk({tag, "_ready"}, {31'd0, CMD_READY}, 32'd0);
        chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
        chk({tag, "_cur"}, CUR_PW, 32'd0);
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd1);
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge PCLK);
            if (BUSY === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_idle_timeout"}, {31'd0, done}, 32'd1);
    endtask

    task automatic send_cmd(input string tag, input logic [31:0] v, output int acc);
        bit ok;
        ok = 1'b0;
        @(negedge PCLK);
        CMD_VALID = 1'b1;
        CMD_TARGET = v;
        for (int i = 0; i < 100; i++) begin
            if (CMD_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        chk({tag, "_accept"}, {31'd0, ok}, 32'd1);
        @(posedge PCLK);
        #1;
        acc = cyc;
        CMD_VALID = 1'b0;
    endtask

    task automatic check_init(input string tag, input int b);
        chk({tag, "_count"}, wq.size() - b, 32'd2);
        if (wq.size() >= b + 2) begin
            chk({tag, "_per_addr"}, wq[b].a, 32'd0);
            chk({tag, "_per_data"}, wq[b].d, 32'd5000);
            chk({tag, "_pw_addr"}, wq[b+1].a, 32'd4);
            chk({tag, "_pw_data"}, wq[b+1].d, 32'd0);
        end
        chk({tag, "_ready"}, {31'd0, CMD_READY}, 32'd1);
        chk({tag, "_cur"}, CUR_PW, 32'd0);
    endtask

    initial begin
        int acc, n, b, sb, pe;
        bit seen;
        logic [31:0] t, mx, model_cur;

        // 1: reset and init sequence
        reset_checks("rst1");
        b = wq.size();
        wait_idle("init1", 100);
        check_init("init1", b);

        // 2: ramp 0 -> 200 with interval timing
        b = wq.size();
        sb = st.size();
        send_cmd("t200", 32'd200, acc);
        wait_idle("t200", 300);
        check_ramp("t200", 32'd0, 32'd200, b, n);
        chk("t200_count", wq.size() - b, n);
        chk("t200_setups", st.size() - sb, 32'd4);
        if (st.size() > sb) chk("t200_first_setup", st[sb] - acc, 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (sb + i < st.size()) chk("t200_gap", st[sb+i] - st[sb+i-1], 32'd6);
        end
        chk("t200_cur", CUR_PW, 32'd200);

        // 3: ramp down, then clamped climb to the period
        b = wq.size();
        send_cmd("t120", 32'd120, acc);
        wait_idle("t120", 300);
        check_ramp("t120", 32'd200, 32'd120, b, n);
        chk("t120_count", wq.size() - b, n);
        b = wq.size();
        send_cmd("t9000", 32'd9000, acc);
        wait_idle("t9000", 3000);
        check_ramp("t9000", 32'd120, 32'd9000, b, n);
        chk("t9000_count", wq.size() - b, n);
        if (wq.size() > 0) chk("t9000_last", wq[wq.size()-1].d, 32'd5000);
        chk("t9000_cur", CUR_PW, 32'd5000);

        // 4: retarget mid-ramp, then a no-op command
        reset_checks("rst2");
        wait_idle("init2", 100);
        b = wq.size();
        send_cmd("t300", 32'd300, acc);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (CUR_PW === 32'd50) begin
                seen = 1'b1;
                break;
            end
        end
        chk("retgt_reach50", {31'd0, seen}, 32'd1);
        send_cmd("t75", 32'd75, acc);
        wait_idle("t75", 300);
        if (wq.size() > b) chk("retgt_first", wq[b].d, step_model(32'd0, 32'd300));
        check_ramp("retgt", 32'd50, 32'd75, b + 1, n);
        chk("retgt_count", wq.size() - b, n + 1);
        mx = 32'd0;
        for (int i = b; i < wq.size(); i++) if (wq[i].d > mx) mx = wq[i].d;
        chk("retgt_max", mx, 32'd75);
        chk("retgt_cur", CUR_PW, 32'd75);
        b = wq.size();
        sb = st.size();
        send_cmd("same", 32'd75, acc);
        chk("same_busy_now", {31'd0, BUSY}, 32'd0);
        repeat (8) @(negedge PCLK);
        chk("same_no_write", wq.size() - b, 32'd0);
        chk("same_no_setup", st.size() - sb, 32'd0);
        chk("same_busy", {31'd0, BUSY}, 32'd0);

        // 5: three slave wait states on one step write
        ws_req = 3;
        b = wq.size();
        send_cmd("ws", 32'd125, acc);
        pe = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (M_PENABLE === 1'b1) begin
                pe++;
                chk("ws_cur_hold", CUR_PW, 32'd75);
                if (M_PREADY === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
        end
        ws_req = 0;
        chk("ws_done", {31'd0, seen}, 32'd1);
        chk("ws_penable_cycles", pe, 32'd4);
        @(negedge PCLK);
        chk("ws_cur_update", CUR_PW, 32'd125);
        wait_idle("ws", 100);
        chk("ws_count", wq.size() - b, 32'd1);
        if (wq.size() > b) chk("ws_data", wq[b].d, 32'd125);

        // 6: slave error on a step write, then reset during ACCESS
        reset_checks("rst3");
        wait_idle("init3", 100);
        err_data = 32'd100;
        err_en = 1'b1;
        b = wq.size();
        send_cmd("err", 32'd200, acc);
        wait_idle("err", 300);
        err_en = 1'b0;
        chk("err_count", wq.size() - b, 32'd2);
        if (wq.size() >= b + 2) begin
            chk("err_w0_data", wq[b].d, 32'd50);
            chk("err_w0_slverr", {31'd0, wq[b].e}, 32'd0);
            chk("err_w1_data", wq[b+1].d, 32'd100);
            chk("err_w1_slverr", {31'd0, wq[b+1].e}, 32'd1);
        end
        chk("err_flag", {31'd0, ERR}, 32'd1);
        chk("err_cur", CUR_PW, 32'd50);
        chk("err_busy", {31'd0, BUSY}, 32'd0);
        ws_req = 3;
        send_cmd("abort", 32'd300, acc);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (M_PENABLE === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort_in_access", {31'd0, seen}, 32'd1);
        ws_req = 0;
        reset_checks("abort_rst");
        b = wq.size();
        wait_idle("init4", 100);
        check_init("init4", b);

        // Random targets with random wait states
        model_cur = 32'd0;
        for (int k = 0; k < 6; k++) begin
            t = $urandom_range(0, 6000);
            ws_req = $urandom_range(0, 2);
            b = wq.size();
            send_cmd("rnd", t, acc);
            wait_idle("rnd", 4000);
            check_ramp("rnd", model_cur, t, b, n);
            chk("rnd_count", wq.size() - b, n);
            chk("rnd_cur", CUR_PW, clamp(t));
            model_cur = clamp(t);
        end
        ws_req = 0;

        chk("protocol_violations", proto_err, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
